// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with a one-word holding buffer so that
// consecutive words leave the line back-to-back with no idle bit between them.
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit SHIFT_DIR = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             enable,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]    bit_count, bit_count_nxt;
    logic [WIDTH-1:0] hold, hold_nxt;
    logic             hold_full, hold_full_nxt;
    logic             done_nxt;

    logic             load_fire;
    logic             last_bit;
    logic             bypass;
    logic [WIDTH-1:0] shreg_shifted;

    assign load_fire = load_valid & load_ready;
    assign last_bit  = (bit_count == LAST_BIT);

    // The consumed bit leaves at the output end; zero fill enters the other end.
    assign shreg_shifted = SHIFT_DIR ? {shreg[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg[WIDTH-1:1]};

    assign load_ready = ~hold_full;
    assign busy       = (state == SHIFT);
    assign out_valid  = busy & enable;
    assign out        = busy & (SHIFT_DIR ? shreg[WIDTH-1] : shreg[0]);

    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        state_nxt     = state;
        shreg_nxt     = shreg;
        bit_count_nxt = bit_count;
        hold_nxt      = hold;
        hold_full_nxt = hold_full;
        done_nxt      = 1'b0;
        bypass        = 1'b0;

        unique case (state)
            IDLE: begin
                if (load_fire) begin
                    shreg_nxt     = load_data;
                    bit_count_nxt = '0;
                    state_nxt     = SHIFT;
                end
            end

            SHIFT: begin
                if (enable) begin
                    if (!last_bit) begin
                        shreg_nxt     = shreg_shifted;
                        bit_count_nxt = bit_count + CNT_ONE;
                    end else begin
                        done_nxt      = 1'b1;
                        bit_count_nxt = '0;
                        if (hold_full) begin
                            shreg_nxt     = hold;
                            hold_full_nxt = 1'b0;
                        end else if (load_fire) begin
                            shreg_nxt = load_data;
                            bypass    = 1'b1;
                        end else begin
                            shreg_nxt = shreg_shifted;
                            state_nxt = IDLE;
                        end
                    end
                end

                // load_ready is low while hold_full, so this never overwrites a held word.
                if (load_fire && !bypass) begin
                    hold_nxt      = load_data;
                    hold_full_nxt = 1'b1;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_count <= '0;
            hold_full <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            bit_count <= bit_count_nxt;
            hold_full <= hold_full_nxt;
            done      <= done_nxt;
        end
    end

    // NOTE: hold is pure data qualified by hold_full, so it carries no reset.
    always_ff @(posedge clk) begin
        hold <= hold_nxt;
    end

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: LSB-first and MSB-first instances share stimulus
// and are checked against a word-queue model of the serial line.
module tb_piso_tx;

    localparam int W = 8;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] load_data;
    logic         load_valid;
    logic         enable;

    logic l_ready, l_out, l_valid, l_busy, l_done;
    logic m_ready, m_out, m_valid, m_busy, m_done;

    piso_tx #(.WIDTH(W), .SHIFT_DIR(1'b0)) u_lsb (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (l_ready),
        .enable     (enable),
        .out        (l_out),
        .out_valid  (l_valid),
        .busy       (l_busy),
        .done       (l_done)
    );

    piso_tx #(.WIDTH(W), .SHIFT_DIR(1'b1)) u_msb (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (m_ready),
        .enable     (enable),
        .out        (m_out),
        .out_valid  (m_valid),
        .busy       (m_busy),
        .done       (m_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: accepted words queued in order; the front word is the one on the line.
    logic [W-1:0] exp_words[$];
    int           bit_idx   = 0;
    int           in_flight = 0;
    logic         done_exp  = 1'b0;

    always @(negedge clk) begin
        logic [W-1:0] cur;
        logic         exp_busy, exp_ready, exp_l, exp_m, fire, last;
        if (!reset_n) begin
            exp_words.delete();
            bit_idx   = 0;
            in_flight = 0;
            done_exp  = 1'b0;
        end else begin
            exp_busy  = (in_flight > 0);
            exp_ready = (in_flight < 2);
            cur       = (exp_words.size() > 0) ? exp_words[0] : '0;
            if (exp_busy) check("sb_nonempty", 32'(exp_words.size() != 0), 1);
            exp_l = exp_busy & cur[bit_idx];
            exp_m = exp_busy & cur[W-1-bit_idx];

            check("lsb_out",       l_out,   exp_l);
            check("msb_out",       m_out,   exp_m);
            check("lsb_out_valid", l_valid, exp_busy & enable);
            check("msb_out_valid", m_valid, exp_busy & enable);
            check("lsb_busy",      l_busy,  exp_busy);
            check("msb_busy",      m_busy,  exp_busy);
            check("lsb_ready",     l_ready, exp_ready);
            check("msb_ready",     m_ready, exp_ready);
            check("lsb_done",      l_done,  done_exp);
            check("msb_done",      m_done,  done_exp);

            fire = load_valid & exp_ready;
            last = 1'b0;
            if (exp_busy && enable) begin
                if (bit_idx == W - 1) begin
                    void'(exp_words.pop_front());
                    bit_idx = 0;
                    last    = 1'b1;
                end else begin
                    bit_idx++;
                end
            end
            in_flight = in_flight + int'(fire) - int'(last);
            done_exp  = last;
        end
    end

    logic rand_en = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_en) enable = ($urandom_range(0, 3) != 0);
    endtask

    // Present a word and hold it until accepted; the expected word is queued
    // at the negedge preceding the accepting edge.
    task automatic send(input logic [W-1:0] w);
        bit got = 1'b0;
        load_data  = w;
        load_valid = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (l_ready) begin
                exp_words.push_back(w);
                got = 1'b1;
            end
            tick();
        end
        load_valid = 1'b0;
        if (!got) check("load_accept_timeout", 0, 1);
    endtask

    initial begin
        reset_n    = 1'b0;
        load_data  = '0;
        load_valid = 1'b0;
        enable     = 1'b0;

        #2;
        check("rst_out",       l_out,   0);
        check("rst_out_valid", l_valid, 0);
        check("rst_busy",      l_busy,  0);
        check("rst_done",      l_done,  0);
        check("rst_ready",     l_ready, 1);
        #5 reset_n = 1'b1;
        tick();

        // LSB/MSB ordering of 0x0F with enable held high.
        enable = 1'b1;
        send(8'h0F);
        repeat (12) tick();

        // Stall after the fourth bit for three cycles.
        send(8'hA5);
        repeat (4) tick();
        enable = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        repeat (10) tick();

        // Back-to-back through the hold buffer.
        send(8'h0F);
        tick();
        send(8'hF0);
        repeat (20) tick();

        // Bypass: next word presented exactly at the last-bit edge.
        send(8'h3C);
        repeat (7) tick();
        send(8'h81);
        repeat (12) tick();

        // Reset mid-frame, with a load presented during reset.
        send(8'hC3);
        repeat (2) tick();
        #2;
        reset_n    = 1'b0;
        load_data  = 8'hFF;
        load_valid = 1'b1;
        #1;
        check("mid_rst_out",       l_out,   0);
        check("mid_rst_out_valid", l_valid, 0);
        check("mid_rst_busy",      l_busy,  0);
        check("mid_rst_done",      l_done,  0);
        check("mid_rst_ready",     l_ready, 1);
        check("mid_rst_msb_busy",  m_busy,  0);
        tick();
        tick();
        load_valid = 1'b0;
        #2 reset_n = 1'b1;
        tick();
        send(8'h0F);
        repeat (12) tick();

        // Randomized words, gaps and enable pattern.
        rand_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            send(W'($urandom()));
            repeat ($urandom_range(0, 3)) tick();
        end
        rand_en = 1'b0;
        enable  = 1'b1;
        repeat (40) tick();

        check("scoreboard_drained", 32'(exp_words.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
